// File: rtl/uart_cfg_sequencer.sv
// rtl/uart_cfg_sequencer.sv - UART frame-format sequencer applying host and remote updates at safe points
// Optional handshake timeout enabled by defining UART_CFG_TIMEOUT_EN.
module uart_cfg_sequencer #(
  parameter logic [1:0]  RST_DATA_WIDTH  = 2'b11,
  parameter logic [1:0]  RST_STOP_BITS   = 2'b00,
  parameter logic [1:0]  RST_PARITY_MODE = 2'b00,
  parameter int unsigned TIMEOUT_CYCLES  = 65535
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cfg_wr_i,
  input  logic [1:0] cfg_data_width_i,
  input  logic [1:0] cfg_stop_bits_i,
  input  logic [1:0] cfg_parity_mode_i,
  output logic       cfg_busy_o,
  output logic       cfg_done_o,
  output logic       cfg_error_o,
  input  logic       tx_fifo_empty_i,
  input  logic       tx_done_i,
  output logic       tx_hold_o,
  output logic       tx_config_req_o,
  input  logic       tx_req_done_i,
  input  logic       rx_config_req_i,
  output logic       rx_req_ackn_o,
  input  logic       rx_done_i,
  input  logic [7:0] rx_data_i,
  output logic [1:0] data_width_o,
  output logic [1:0] stop_bits_number_o,
  output logic [1:0] parity_mode_o
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_DRAIN    = 3'd1;
  localparam logic [2:0] ST_REQ_MST  = 3'd2;
  localparam logic [2:0] ST_SLV_ACK  = 3'd3;
  localparam logic [2:0] ST_SLV_DATA = 3'd4;
  localparam logic [2:0] ST_APPLY    = 3'd5;

  // Format vectors share the remote byte layout: {parity, stop, width}.
  localparam logic [5:0] RST_FMT = {RST_PARITY_MODE, RST_STOP_BITS, RST_DATA_WIDTH};

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       pend_valid;
  logic [5:0] pend_fmt;
  logic [5:0] apply_fmt;
  logic       apply_host;
  logic [5:0] fmt_q;
  logic       done_q;
  logic       err_q;
  logic       waiting;
  logic       timeout;
  logic       timeout_fire;
  logic       bad_byte;
  logic       host_to_apply;
  logic       remote_to_apply;

  assign waiting  = (state == ST_DRAIN) || (state == ST_REQ_MST) || (state == ST_SLV_DATA);
  assign bad_byte = (state == ST_SLV_DATA) && rx_done_i && (rx_data_i[7:6] != 2'b00);

  always_comb begin
    state_nxt    = state;
    timeout_fire = 1'b0;
    case (state)
      ST_IDLE: begin
        // A committed remote request is served before any pending host write.
        if (rx_config_req_i) begin
          state_nxt = ST_SLV_ACK;
        end else if (pend_valid || cfg_wr_i) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (tx_fifo_empty_i && tx_done_i) begin
          state_nxt = ST_REQ_MST;
        end else if (timeout) begin
          state_nxt    = ST_IDLE;
          timeout_fire = 1'b1;
        end
      end
      ST_REQ_MST: begin
        if (tx_req_done_i) begin
          state_nxt = ST_APPLY;
        end else if (timeout) begin
          state_nxt    = ST_IDLE;
          timeout_fire = 1'b1;
        end
      end
      ST_SLV_ACK: begin
        state_nxt = ST_SLV_DATA;
      end
      ST_SLV_DATA: begin
        if (rx_done_i) begin
          state_nxt = (rx_data_i[7:6] == 2'b00) ? ST_APPLY : ST_IDLE;
        end else if (timeout) begin
          state_nxt    = ST_IDLE;
          timeout_fire = 1'b1;
        end
      end
      ST_APPLY: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign host_to_apply   = (state == ST_REQ_MST) && (state_nxt == ST_APPLY);
  assign remote_to_apply = (state == ST_SLV_DATA) && (state_nxt == ST_APPLY);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      pend_valid <= 1'b0;
      pend_fmt   <= 6'd0;
      apply_fmt  <= 6'd0;
      apply_host <= 1'b0;
      fmt_q      <= RST_FMT;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= (state == ST_APPLY);
      err_q  <= bad_byte || timeout_fire;
      if (state == ST_APPLY) begin
        fmt_q <= apply_fmt;
      end
      if (host_to_apply) begin
        apply_fmt  <= pend_fmt;
        apply_host <= 1'b1;
      end else if (remote_to_apply) begin
        apply_fmt  <= rx_data_i[5:0];
        apply_host <= 1'b0;
      end
      // A new write always wins the slot, even in the cycle the old one is consumed.
      if (cfg_wr_i) begin
        pend_valid <= 1'b1;
        pend_fmt   <= {cfg_parity_mode_i, cfg_stop_bits_i, cfg_data_width_i};
      end else if (host_to_apply || timeout_fire) begin
        pend_valid <= 1'b0;
      end
    end
  end

`ifdef UART_CFG_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] to_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || (state_nxt != state) || !waiting) begin
      to_cnt <= 32'd0;
    end else begin
      to_cnt <= to_cnt + 32'd1;
    end
  end

  assign timeout = waiting && (to_cnt == TO_LAST);
`else
  // Without the timeout build the waiting states never give up.
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = (TIMEOUT_CYCLES == 0) && waiting;
  assign timeout               = 1'b0;
`endif

  assign cfg_busy_o         = (state != ST_IDLE) || pend_valid;
  assign cfg_done_o         = done_q;
  assign cfg_error_o        = err_q;
  assign tx_hold_o          = (state == ST_DRAIN) || (state == ST_REQ_MST) ||
                              ((state == ST_APPLY) && apply_host);
  assign tx_config_req_o    = (state == ST_REQ_MST);
  assign rx_req_ackn_o      = (state == ST_SLV_ACK);
  assign data_width_o       = fmt_q[1:0];
  assign stop_bits_number_o = fmt_q[3:2];
  assign parity_mode_o      = fmt_q[5:4];

endmodule

// File: tb/tb_uart_cfg_sequencer.sv
// tb/tb_uart_cfg_sequencer.sv - self-checking bench for uart_cfg_sequencer
// Expectations are scheduled per cycle from the transaction timing rules.
module tb_uart_cfg_sequencer;

`ifdef UART_CFG_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 65535;
`endif
  localparam int NC = 4096;
  localparam int P_DW = 0, P_SB = 1, P_PM = 2, P_REQ = 3, P_DONE = 4, P_BUSY = 5, P_ERR = 6, P_ACK = 7;
  localparam int K_DONE = 0, K_ERR = 1, K_REQ = 2, K_ACK = 3, K_HOLD = 4, K_BUSY = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_wr;
  logic [1:0] cfg_dw, cfg_sb, cfg_pm;
  logic       cfg_busy, cfg_done, cfg_error;
  logic       tx_fifo_empty, tx_done, tx_hold, tx_config_req, tx_req_done;
  logic       rx_config_req, rx_req_ackn, rx_done;
  logic [7:0] rx_data;
  logic [1:0] data_width, stop_bits, parity_mode;

  always #5 clk = ~clk;

  uart_cfg_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .cfg_wr_i(cfg_wr), .cfg_data_width_i(cfg_dw), .cfg_stop_bits_i(cfg_sb), .cfg_parity_mode_i(cfg_pm),
    .cfg_busy_o(cfg_busy), .cfg_done_o(cfg_done), .cfg_error_o(cfg_error),
    .tx_fifo_empty_i(tx_fifo_empty), .tx_done_i(tx_done), .tx_hold_o(tx_hold),
    .tx_config_req_o(tx_config_req), .tx_req_done_i(tx_req_done),
    .rx_config_req_i(rx_config_req), .rx_req_ackn_o(rx_req_ackn),
    .rx_done_i(rx_done), .rx_data_i(rx_data),
    .data_width_o(data_width), .stop_bits_number_o(stop_bits), .parity_mode_o(parity_mode)
  );

  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  bit         chk_en = 1'b0;
  bit         e_done[NC], e_err[NC], e_req[NC], e_ack[NC], e_hold[NC], e_busy[NC];
  bit         f_set[NC];
  logic [5:0] f_val[NC];
  bit   [7:0] sp_mask[NC];
  logic [1:0] sp_exp[NC][8];
  logic [5:0] m_fmt;
  logic [11:0] exp_v, act_v;
  logic [1:0] got;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string pin_name(input int k);
    case (k)
      P_DW: return "pin_data_width";
      P_SB: return "pin_stop_bits";
      P_PM: return "pin_parity";
      P_REQ: return "pin_tx_config_req";
      P_DONE: return "pin_cfg_done";
      P_BUSY: return "pin_cfg_busy";
      P_ERR: return "pin_cfg_error";
      default: return "pin_rx_req_ackn";
    endcase
  endfunction

  // Single compare process: full output vector every cycle, plus literal pins.
  always @(negedge clk) begin
    if (chk_en && cyc < NC) begin
      if (f_set[cyc]) m_fmt = f_val[cyc];
      exp_v = {m_fmt, e_done[cyc], e_err[cyc], e_req[cyc], e_ack[cyc], e_hold[cyc], e_busy[cyc]};
      act_v = {parity_mode, stop_bits, data_width, cfg_done, cfg_error, tx_config_req,
               rx_req_ackn, tx_hold, cfg_busy};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL cycle_check cyc=%0d got=%b want=%b (fmt,done,err,req,ack,hold,busy)",
                 cyc, act_v, exp_v);
      end
      for (int k = 0; k < 8; k++) begin
        if (sp_mask[cyc][k]) begin
          case (k)
            P_DW: got = data_width;
            P_SB: got = stop_bits;
            P_PM: got = parity_mode;
            P_REQ: got = {1'b0, tx_config_req};
            P_DONE: got = {1'b0, cfg_done};
            P_BUSY: got = {1'b0, cfg_busy};
            P_ERR: got = {1'b0, cfg_error};
            default: got = {1'b0, rx_req_ackn};
          endcase
          checks++;
          if (got !== sp_exp[cyc][k]) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%b want=%b", pin_name(k), cyc, got, sp_exp[cyc][k]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cfg_wr = 1'b0; rx_config_req = 1'b0; rx_done = 1'b0; tx_req_done = 1'b0;
    tx_fifo_empty = 1'b1; tx_done = 1'b1;
  endtask

  task automatic mark(input int kind, input int a, input int b);
    for (int c = a; c <= b; c++) begin
      if (c >= 0 && c < NC) begin
        case (kind)
          K_DONE: e_done[c] = 1'b1;
          K_ERR: e_err[c] = 1'b1;
          K_REQ: e_req[c] = 1'b1;
          K_ACK: e_ack[c] = 1'b1;
          K_HOLD: e_hold[c] = 1'b1;
          default: e_busy[c] = 1'b1;
        endcase
      end
    end
  endtask

  task automatic set_fmt(input int c, input logic [5:0] v);
    if (c < NC) begin f_set[c] = 1'b1; f_val[c] = v; end
  endtask

  task automatic pin(input int c, input int k, input logic [1:0] v);
    if (c < NC) begin sp_mask[c][k] = 1'b1; sp_exp[c][k] = v; end
  endtask

  task automatic drive_fmt(input logic [5:0] f);
    {cfg_pm, cfg_sb, cfg_dw} = f;
  endtask

  // Host update: write at N, TX idle at N+drain, tx_req_done after w cycles in REQ_MST.
  task automatic host_update(input logic [5:0] f, input int drain, input int w,
                             input logic [5:0] f2, input int s);
    int n, fe, r, m;
    n = cyc; fe = n + drain;
    r = (n + 2 > fe + 1) ? n + 2 : fe + 1;
    m = r + w;
    mark(K_BUSY, n + 1, m + 1);
    mark(K_HOLD, n + 1, m + 1);
    mark(K_REQ, r, m);
    mark(K_DONE, m + 2, m + 2);
    set_fmt(m + 2, (s > 0) ? f2 : f);
    for (int c = n; c <= m + 1; c++) begin
      cfg_wr = (c == n) || (s > 0 && c == n + s);
      drive_fmt((c == n) ? f : f2);
      tx_fifo_empty = (c >= fe);
      tx_done = (c >= fe);
      tx_req_done = (c == m);
      tick();
    end
    idle_inputs();
  endtask

  // Remote update: request at K, byte after d cycles in SLV_DATA.
  task automatic remote_update(input logic [7:0] b, input int d);
    int k, j, last;
    bit good;
    k = cyc; j = k + 2 + d; good = (b[7:6] == 2'b00);
    last = good ? j + 1 : j;
    mark(K_ACK, k + 1, k + 1);
    mark(K_BUSY, k + 1, last);
    if (good) begin
      mark(K_DONE, j + 2, j + 2);
      set_fmt(j + 2, b[5:0]);
    end else begin
      mark(K_ERR, j + 1, j + 1);
    end
    for (int c = k; c <= last; c++) begin
      rx_config_req = (c == k);
      rx_done = (c == j);
      rx_data = (c == j) ? b : 8'($urandom);
      tick();
    end
    idle_inputs();
  endtask

  // Host write and remote request in the same IDLE cycle: remote first, host afterwards.
  task automatic collision(input logic [5:0] fa, input logic [5:0] fb, input int d, input int w);
    int k, j, r, m;
    k = cyc; j = k + 2 + d; r = j + 4; m = r + w;
    mark(K_ACK, k + 1, k + 1);
    mark(K_BUSY, k + 1, m + 1);
    mark(K_DONE, j + 2, j + 2);
    set_fmt(j + 2, fb);
    mark(K_HOLD, j + 3, m + 1);
    mark(K_REQ, r, m);
    mark(K_DONE, m + 2, m + 2);
    set_fmt(m + 2, fa);
    for (int c = k; c <= m + 1; c++) begin
      cfg_wr = (c == k);
      drive_fmt(fa);
      rx_config_req = (c == k);
      rx_done = (c == j);
      rx_data = {2'b00, fb};
      tx_req_done = (c == m);
      tick();
    end
    idle_inputs();
  endtask

  // Reset asserted w0 cycles into REQ_MST.
  task automatic reset_abort(input logic [5:0] f, input int w0);
    int n, r, a;
    n = cyc; r = n + 2; a = r + w0;
    mark(K_BUSY, n + 1, a);
    mark(K_HOLD, n + 1, a);
    mark(K_REQ, r, a);
    set_fmt(a + 1, 6'h03);
    pin(a + 1, P_REQ, 2'b00);
    pin(a + 1, P_BUSY, 2'b00);
    pin(a + 1, P_DW, 2'b11);
    for (int c = n; c <= a; c++) begin
      cfg_wr = (c == n);
      drive_fmt(f);
      rst = (c == a);
      tick();
    end
    rst = 1'b0;
    idle_inputs();
  endtask

`ifdef UART_CFG_TIMEOUT_EN
  task automatic timeout_case(input logic [5:0] f);
    int n, r;
    n = cyc; r = n + 2;
    mark(K_BUSY, n + 1, r + TO - 1);
    mark(K_HOLD, n + 1, r + TO - 1);
    mark(K_REQ, r, r + TO - 1);
    mark(K_ERR, r + TO, r + TO);
    pin(r + 16, P_ERR, 2'b01);
    pin(r + 16, P_BUSY, 2'b00);
    for (int c = n; c <= r + TO - 1; c++) begin
      cfg_wr = (c == n);
      drive_fmt(f);
      tick();
    end
    idle_inputs();
  endtask
`endif

  initial begin
    int n, kind, dr, w, s;
    logic [7:0] b;
    logic [5:0] fa;
    rst = 1'b1;
    cfg_dw = 2'b00; cfg_sb = 2'b00; cfg_pm = 2'b00; rx_data = 8'h00;
    idle_inputs();
    repeat (3) tick();
    rst = 1'b0;
    set_fmt(cyc, 6'h03);
    pin(cyc, P_DW, 2'b11);
    pin(cyc, P_SB, 2'b00);
    pin(cyc, P_PM, 2'b00);
    pin(cyc, P_BUSY, 2'b00);
    chk_en = 1'b1;
    tick();

    // Host 01/01/10: request from N+2, tx_req_done at N+5, new format at N+7.
    n = cyc;
    pin(n + 1, P_REQ, 2'b00);
    pin(n + 2, P_REQ, 2'b01);
    pin(n + 6, P_DONE, 2'b00);
    pin(n + 7, P_DONE, 2'b01);
    pin(n + 7, P_DW, 2'b01);
    pin(n + 7, P_SB, 2'b01);
    pin(n + 7, P_PM, 2'b10);
    host_update(6'b10_01_01, 0, 3, 6'd0, 0);
    tick();

    // FIFO busy for 20 cycles: REQ_MST one cycle after it empties.
    n = cyc;
    pin(n + 20, P_REQ, 2'b00);
    pin(n + 21, P_REQ, 2'b01);
    host_update(6'b00_00_10, 20, 0, 6'd0, 0);

    // Remote byte 00_10_01_00 then a reserved-bit byte.
    n = cyc;
    pin(n + 1, P_ACK, 2'b01);
    pin(n + 2, P_ACK, 2'b00);
    pin(n + 6, P_DW, 2'b00);
    pin(n + 6, P_SB, 2'b01);
    pin(n + 6, P_PM, 2'b10);
    remote_update(8'b00_10_01_00, 2);
    n = cyc;
    pin(n + 4, P_ERR, 2'b01);
    pin(n + 5, P_DW, 2'b00);
    pin(n + 5, P_PM, 2'b10);
    remote_update(8'hC0, 1);
    tick();

    collision(6'b01_10_11, 6'b11_01_00, 1, 2);
    host_update(6'b11_11_11, 5, 1, 6'b00_10_01, 2);
    host_update(6'b01_00_01, 0, 0, 6'd0, 0);
    reset_abort(6'b10_10_10, 3);
    tick();
`ifdef UART_CFG_TIMEOUT_EN
    timeout_case(6'b01_01_01);
    tick();
`endif

    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 4);
      fa = 6'($urandom);
      dr = $urandom_range(0, 6);
      w = $urandom_range(0, 5);
      case (kind)
        0: host_update(fa, dr, w, 6'd0, 0);
        1: begin
          s = $urandom_range(1, ((dr + 1 > 2) ? dr + 1 : 2) - 1);
          host_update(fa, dr, w, 6'($urandom), s);
        end
        2: begin
          b = 8'($urandom);
          if ($urandom_range(0, 3) != 0) b[7:6] = 2'b00;
          else if (b[7:6] == 2'b00) b[7:6] = 2'b01;
          remote_update(b, $urandom_range(0, 4));
        end
        3: collision(fa, 6'($urandom), $urandom_range(0, 3), w);
        default: repeat ($urandom_range(0, 3)) tick();
      endcase
    end

    repeat (4) tick();
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
